// File: rtl/ex_fwd_pipe_pkg.sv
// ============================================================================
// Module : ex_fwd_pipe_pkg
// Brief  : Shared widths, forward-select encoding and pipeline-register
//          layouts for the execute-side forwarding block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_fwd_pipe_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RA_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            is_load;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] result;
   } exm_t;

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] result;
   } mwb_t;

   // A live producer that writes a non-zero rd matching the source address.
   function automatic logic dst_hit(input logic            valid,
                                    input logic            reg_write,
                                    input logic [RA_W-1:0] rd,
                                    input logic [RA_W-1:0] src);
      return valid & reg_write & (rd != '0) & (rd == src);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_fwd_pipe_if.sv
// ============================================================================
// Module : ex_fwd_pipe_if
// Brief  : ID/EX-side bus into the forwarding block and its ALU operand,
//          stall and write-back outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_fwd_pipe_if;
   import ex_fwd_pipe_pkg::*;

   logic            id_valid;
   logic [RA_W-1:0] id_rs1;
   logic [RA_W-1:0] id_rs2;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [RA_W-1:0] id_rd;
   logic            id_reg_write;
   logic            id_is_load;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] mem_rdata;
   logic            flush;

   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [1:0]      fwd_a_sel;
   logic [1:0]      fwd_b_sel;
   logic            load_use_stall;
   logic            wb_we;
   logic [RA_W-1:0] wb_rd;
   logic [XLEN-1:0] wb_data;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
             id_reg_write, id_is_load, alu_result, mem_rdata, flush,
      input  op_a, op_b, fwd_a_sel, fwd_b_sel, load_use_stall,
             wb_we, wb_rd, wb_data
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_rd,
             id_reg_write, id_is_load, alu_result, mem_rdata, flush,
      output op_a, op_b, fwd_a_sel, fwd_b_sel, load_use_stall,
             wb_we, wb_rd, wb_data
   );

endinterface

`default_nettype wire

// File: rtl/ex_fwd_pipe_fwd_sel_unit.sv
// ============================================================================
// Module : fwd_sel_unit
// Brief  : Per-operand hit detection and priority mux (EX/MEM > MEM/WB > RF).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_sel_unit
   import ex_fwd_pipe_pkg::*;
(
   input  logic [RA_W-1:0] src,
   input  logic [XLEN-1:0] rf_data,
   input  exm_t            exm,
   input  mwb_t            mwb,
   output fwd_sel_e        sel,
   output logic [XLEN-1:0] op
);

   logic w_exm_hit;
   logic w_mwb_hit;

   // A load in EX/MEM has no data yet; that case is covered by the stall.
   assign w_exm_hit = dst_hit(exm.valid, exm.reg_write, exm.rd, src) & ~exm.is_load;
   assign w_mwb_hit = dst_hit(mwb.valid, mwb.reg_write, mwb.rd, src);

   always_comb begin
      sel = FWD_RF;
      op  = rf_data;
      if (w_exm_hit) begin
         sel = FWD_EXM;
         op  = exm.result;
      end else if (w_mwb_hit) begin
         sel = FWD_MWB;
         op  = mwb.result;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_fwd_pipe.sv
// ============================================================================
// Module : ex_fwd_pipe
// Brief  : EX/MEM and MEM/WB pipeline registers, operand forwarding,
//          load-use stall request and register-file write-back port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_fwd_pipe
   import ex_fwd_pipe_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   ex_fwd_pipe_if.slave  bus
);

   exm_t            r_exm;
   mwb_t            r_mwb;
   logic            w_stall;
   logic [RA_W-1:0] w_src     [2];
   logic [XLEN-1:0] w_rf_data [2];
   fwd_sel_e        w_sel     [2];
   logic [XLEN-1:0] w_op      [2];

   assign w_src[0]     = bus.id_rs1;
   assign w_src[1]     = bus.id_rs2;
   assign w_rf_data[0] = bus.id_rs1_data;
   assign w_rf_data[1] = bus.id_rs2_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         fwd_sel_unit u_fwd (
            .src     (w_src[gi]),
            .rf_data (w_rf_data[gi]),
            .exm     (r_exm),
            .mwb     (r_mwb),
            .sel     (w_sel[gi]),
            .op      (w_op[gi])
         );
      end
   endgenerate

   assign bus.op_a      = w_op[0];
   assign bus.op_b      = w_op[1];
   assign bus.fwd_a_sel = w_sel[0];
   assign bus.fwd_b_sel = w_sel[1];

   // Conservative: rs2 is matched even for instructions that do not read it.
   assign w_stall = bus.id_valid & r_exm.valid & r_exm.is_load &
                    (dst_hit(1'b1, r_exm.reg_write, r_exm.rd, bus.id_rs1) |
                     dst_hit(1'b1, r_exm.reg_write, r_exm.rd, bus.id_rs2));
   assign bus.load_use_stall = w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exm <= '0;
         r_mwb <= '0;
      end else begin
         r_exm.valid     <= bus.id_valid & ~bus.flush & ~w_stall;
         r_exm.reg_write <= bus.id_reg_write;
         r_exm.is_load   <= bus.id_is_load;
         r_exm.rd        <= bus.id_rd;
         r_exm.result    <= bus.alu_result;

         r_mwb.valid     <= r_exm.valid;
         r_mwb.reg_write <= r_exm.reg_write;
         r_mwb.rd        <= r_exm.rd;
         r_mwb.result    <= r_exm.is_load ? bus.mem_rdata : r_exm.result;
      end
   end

   assign bus.wb_we   = r_mwb.valid & r_mwb.reg_write & (r_mwb.rd != '0);
   assign bus.wb_rd   = r_mwb.rd;
   assign bus.wb_data = r_mwb.result;

endmodule

`default_nettype wire
